// File: rtl/prga_decrypt.sv
// RC4 keystream generator and decryptor. Continues the S-box swaps started by
// the key schedule, XORs each keystream byte with the encrypted ROM and writes
// the plaintext to the decrypted RAM. It can optionally stop at the first
// byte that is neither a space nor a lowercase letter, so that a key-search
// controller can drop a wrong key early.
module prga_decrypt #(
  parameter int MSG_LEN     = 32,
  parameter int MSG_AW      = 5,
  parameter bit CHECK_ASCII = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [MSG_AW-1:0] e_addr,
  input  logic [7:0]        e_q,
  output logic [MSG_AW-1:0] d_addr,
  output logic [7:0]        d_data,
  output logic              d_wren
);

  localparam logic [MSG_AW-1:0] LAST_K = MSG_AW'(MSG_LEN - 1);

  // Nine states per message byte plus three resting states.
  typedef enum logic [3:0] {
    IDLE,
    INC,
    RD_SI,
    LT_SI,
    RD_SJ,
    LT_SJ,
    WR_I,
    WR_J,
    RD_F,
    WR_OUT,
    DONE,
    FAIL
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        i;
  logic [7:0]        j;
  logic [7:0]        si;
  logic [7:0]        sj;
  logic [MSG_AW-1:0] k;
  logic [7:0]        plain;
  logic              plain_ok;

  // During WR_OUT, s_q holds S[si+sj] and e_q holds ROM[k], both addressed in RD_F.
  assign plain    = s_q ^ e_q;
  assign plain_ok = (plain == 8'h20) || ((plain >= 8'h61) && (plain <= 8'h7a));

  assign busy = !(state inside {IDLE, DONE, FAIL});
  assign done = (state == DONE);
  assign fail = (state == FAIL);

  // State register.
  // NOTE: every clocked register uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and memory port decode from the registered state.
  // NOTE: every output gets a default before the case, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    s_addr     = '0;
    s_data     = '0;
    s_wren     = 1'b0;
    e_addr     = '0;
    d_addr     = '0;
    d_data     = '0;
    d_wren     = 1'b0;
    case (state)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_next = INC;
        end
      end
      INC:   state_next = RD_SI;
      RD_SI: begin
        s_addr     = i;
        state_next = LT_SI;
      end
      LT_SI: state_next = RD_SJ;
      RD_SJ: begin
        s_addr     = j;
        state_next = LT_SJ;
      end
      LT_SJ: state_next = WR_I;
      WR_I: begin
        s_addr     = i;
        s_data     = sj;
        s_wren     = 1'b1;
        state_next = WR_J;
      end
      WR_J: begin
        s_addr     = j;
        s_data     = si;
        s_wren     = 1'b1;
        state_next = RD_F;
      end
      RD_F: begin
        s_addr     = si + sj;
        e_addr     = k;
        state_next = WR_OUT;
      end
      WR_OUT: begin
        d_addr = k;
        d_data = plain;
        d_wren = 1'b1;
        if (CHECK_ASCII && !plain_ok) begin
          state_next = FAIL;
        end else if (k == LAST_K) begin
          state_next = DONE;
        end else begin
          state_next = INC;
        end
      end
      default: state_next = IDLE;
    endcase
    // A reset landing on a write cycle must not let that write through.
    if (reset) begin
      s_wren = 1'b0;
      d_wren = 1'b0;
    end
  end

  // Index, swap-value and message-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      i  <= '0;
      j  <= '0;
      si <= '0;
      sj <= '0;
      k  <= '0;
    end else begin
      case (state)
        IDLE, DONE, FAIL: begin
          if (start) begin
            i <= '0;
            j <= '0;
            k <= '0;
          end
        end
        INC: i <= i + 8'd1;
        LT_SI: begin
          si <= s_q;
          j  <= j + s_q;
        end
        LT_SJ: sj <= s_q;
        WR_OUT: begin
          if (state_next == INC) begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt: two instances (plaintext check off / on) with
// behavioural S RAM, encrypted ROM and a write log. A plain RC4 model predicts
// the plaintext, final S contents and pass/fail for each run.
module tb_prga_decrypt;

  localparam int LEN = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start   [2];
  logic       busy    [2];
  logic       done    [2];
  logic       fail    [2];
  logic [7:0] s_addr  [2];
  logic [7:0] s_data  [2];
  logic       s_wren  [2];
  logic [7:0] s_q     [2];
  logic [4:0] e_addr  [2];
  logic [7:0] e_q     [2];
  logic [4:0] d_addr  [2];
  logic [7:0] d_data  [2];
  logic       d_wren  [2];

  logic [7:0] s_mem [2][256];
  logic [7:0] e_mem [2][32];
  logic [7:0] img_s [2][256];
  logic [7:0] img_e [2][32];
  logic       load_req [2];

  typedef struct {
    int n;
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t wlog[$];
  int  swr_cnt = 0;
  int  cyc     = 0;

  int n_pass  = 0;
  int n_total = 0;

  // model results
  int         exp_q[$];
  bit         exp_fail;
  logic [7:0] ref_s [256];

  // results of the latest run
  int last_base;
  int last_t0;
  int last_el;

  always #5 clk = ~clk;

  prga_decrypt #(.MSG_LEN(LEN), .MSG_AW(5), .CHECK_ASCII(1'b0)) dut_a (
    .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .fail(fail[0]), .s_addr(s_addr[0]), .s_data(s_data[0]), .s_wren(s_wren[0]),
    .s_q(s_q[0]), .e_addr(e_addr[0]), .e_q(e_q[0]), .d_addr(d_addr[0]),
    .d_data(d_data[0]), .d_wren(d_wren[0])
  );

  prga_decrypt #(.MSG_LEN(LEN), .MSG_AW(5), .CHECK_ASCII(1'b1)) dut_b (
    .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .fail(fail[1]), .s_addr(s_addr[1]), .s_data(s_data[1]), .s_wren(s_wren[1]),
    .s_q(s_q[1]), .e_addr(e_addr[1]), .e_q(e_q[1]), .d_addr(d_addr[1]),
    .d_data(d_data[1]), .d_wren(d_wren[1])
  );

  // Memories with one-cycle read latency, image loading, and the write log.
  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (load_req[n]) begin
        for (int a = 0; a < 256; a++) s_mem[n][a] <= img_s[n][a];
        for (int a = 0; a < 32; a++)  e_mem[n][a] <= img_e[n][a];
      end else if (s_wren[n]) begin
        s_mem[n][s_addr[n]] <= s_data[n];
      end
      if (s_wren[n]) swr_cnt <= swr_cnt + 1;
      s_q[n] <= s_mem[n][s_addr[n]];
      e_q[n] <= e_mem[n][e_addr[n]];
      if (d_wren[n]) wlog.push_back('{n, cyc, int'(d_addr[n]), int'(d_data[n])});
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit printable(input int b);
    return (b == 32'h20) || (b >= 32'h61 && b <= 32'h7a);
  endfunction

  // Textbook RC4 PRGA over the loaded image, stopping at the first bad byte.
  task automatic model(input int n, input bit chk);
    int s[256];
    int i = 0;
    int j = 0;
    int t;
    int pt;
    for (int a = 0; a < 256; a++) s[a] = int'(img_s[n][a]);
    exp_q.delete();
    exp_fail = 1'b0;
    for (int kk = 0; kk < LEN; kk++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      pt = s[(s[i] + s[j]) % 256] ^ int'(img_e[n][kk]);
      exp_q.push_back(pt);
      if (chk && !printable(pt)) begin
        exp_fail = 1'b1;
        break;
      end
    end
    for (int a = 0; a < 256; a++) ref_s[a] = 8'(s[a]);
  endtask

  task automatic load(input int n);
    @(negedge clk);
    load_req[n] = 1'b1;
    @(negedge clk);
    load_req[n] = 1'b0;
  endtask

  task automatic set_identity(input int n);
    for (int a = 0; a < 256; a++) img_s[n][a] = 8'(a);
  endtask

  task automatic set_perm(input int n);
    logic [7:0] t;
    int y;
    set_identity(n);
    for (int x = 255; x > 0; x--) begin
      y = $urandom_range(x, 0);
      t = img_s[n][x]; img_s[n][x] = img_s[n][y]; img_s[n][y] = t;
    end
  endtask

  // One decryption run; extra re-pulses start while busy, rst_at>0 resets in that cycle.
  task automatic do_run(input int n, input bit chk, input bit extra, input int rst_at);
    int  el = 0;
    int  nwr;
    int  swr_at_rst = 0;
    int  mism = 0;
    bit  ended = 1'b0;
    bit  was_reset = 1'b0;
    model(n, chk);
    @(negedge clk);
    last_base = wlog.size();
    start[n]  = 1'b1;
    last_t0   = cyc;
    while (!ended && el < 300) begin
      @(negedge clk);
      el = cyc - last_t0;
      start[n] = extra && (el == 4 || el == 13);
      if (el == 1) begin
        check("busy_after_start", busy[n], 1);
        check("done_clr_after_start", done[n], 0);
        check("fail_clr_after_start", fail[n], 0);
      end
      if (el == 2) check("rd_si_addr", s_addr[n], 1);
      if (rst_at > 0 && el == rst_at) begin
        reset = 1'b1;
        swr_at_rst = swr_cnt;
      end else if (rst_at > 0 && el == rst_at + 1) begin
        check("rst_busy", busy[n], 0);
        check("rst_done", done[n], 0);
        check("rst_fail", fail[n], 0);
        check("rst_s_wren", s_wren[n], 0);
        check("rst_d_wren", d_wren[n], 0);
        check("rst_s_addr", s_addr[n], 0);
        check("rst_d_addr", d_addr[n], 0);
        reset = 1'b0;
        was_reset = 1'b1;
        ended = 1'b1;
      end else if (done[n] || fail[n]) begin
        ended = 1'b1;
      end
    end
    start[n] = 1'b0;
    last_el  = el;
    check("run_terminated", ended, 1);
    if (was_reset) begin
      repeat (20) @(negedge clk);
      nwr = (rst_at >= 9) ? ((rst_at - 9) / 9 + 1) : 0;
      check("rst_d_writes", wlog.size() - last_base, nwr);
      check("rst_no_s_writes", swr_cnt - swr_at_rst, 0);
      check("rst_idle_busy", busy[n], 0);
    end else if (ended) begin
      check("end_cycle", el, 9 * exp_q.size() + 1);
      check("done_flag", done[n], !exp_fail);
      check("fail_flag", fail[n], exp_fail);
      check("busy_end", busy[n], 0);
      check("n_writes", wlog.size() - last_base, exp_q.size());
      for (int kk = 0; kk < exp_q.size() && last_base + kk < wlog.size(); kk++) begin
        check($sformatf("wr%0d_addr", kk), wlog[last_base + kk].addr, kk);
        check($sformatf("wr%0d_data", kk), wlog[last_base + kk].data, exp_q[kk]);
        check($sformatf("wr%0d_cycle", kk), wlog[last_base + kk].cyc - last_t0, 9 * kk + 9);
      end
      for (int a = 0; a < 256; a++) if (s_mem[n][a] !== ref_s[a]) mism++;
      check("s_final_mismatches", mism, 0);
    end
  endtask

  initial begin
    int  b;
    logic [7:0] tmp [32];
    reset = 1'b1;
    for (int n = 0; n < 2; n++) begin
      start[n]    = 1'b0;
      load_req[n] = 1'b0;
      set_identity(n);
      for (int a = 0; a < 32; a++) img_e[n][a] = 8'h00;
    end
    load(0);
    load(1);
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      check("reset_busy", busy[n], 0);
      check("reset_done", done[n], 0);
      check("reset_fail", fail[n], 0);
      check("reset_s_wren", s_wren[n], 0);
      check("reset_d_wren", d_wren[n], 0);
    end
    reset = 1'b0;

    // Identity S, zero ROM, check off.
    do_run(0, 1'b0, 1'b0, 0);
    check("id_d0", wlog[last_base].data, 8'h02);
    check("id_d1", wlog[last_base + 1].data, 8'h05);
    check("id_d2", wlog[last_base + 2].data, 8'h07);
    check("id_done_cycle", last_el, 28);
    check("id_S2", s_mem[0][2], 8'h03);
    check("id_S3", s_mem[0][3], 8'h05);
    check("id_S5", s_mem[0][5], 8'h02);
    repeat (3) @(negedge clk);
    check("done_held", done[0], 1);

    // Same run with start re-pulsed while busy.
    load(0);
    do_run(0, 1'b0, 1'b1, 0);
    check("reps_done_cycle", last_el, 28);

    // Reset mid-swap, then replay.
    load(0);
    do_run(0, 1'b0, 1'b0, 14);
    load(0);
    do_run(0, 1'b0, 1'b0, 0);
    check("replay_done_cycle", last_el, 28);

    // Check on: all-'a' plaintext.
    img_e[1][0] = 8'h63; img_e[1][1] = 8'h64; img_e[1][2] = 8'h66;
    load(1);
    do_run(1, 1'b1, 1'b0, 0);
    check("ascii_ok_done", done[1], 1);
    check("ascii_ok_fail", fail[1], 0);

    // Check on: second byte decodes to 00.
    img_e[1][1] = 8'h05;
    load(1);
    do_run(1, 1'b1, 1'b0, 0);
    check("ascii_bad_writes", wlog.size() - last_base, 2);
    check("ascii_bad_byte1", wlog[last_base + 1].data, 8'h00);
    check("ascii_bad_fail", fail[1], 1);
    check("ascii_bad_done", done[1], 0);

    // Randomized S permutations and messages.
    for (int r = 0; r < 6; r++) begin
      set_perm(0);
      for (int a = 0; a < 32; a++) img_e[0][a] = 8'($urandom);
      load(0);
      do_run(0, 1'b0, 1'b0, 0);

      set_perm(1);
      for (int a = 0; a < 32; a++) img_e[1][a] = 8'h00;
      model(1, 1'b0);
      for (int a = 0; a < LEN; a++) begin
        b = $urandom_range(26, 0);
        tmp[a] = (b == 26) ? 8'h20 : 8'(8'h61 + b);
        img_e[1][a] = 8'(exp_q[a]) ^ tmp[a];
      end
      if ($urandom_range(1, 0) == 1) begin
        b = $urandom_range(LEN - 1, 0);
        img_e[1][b] = 8'(exp_q[b]) ^ 8'($urandom_range(8'h1f, 0));
      end
      load(1);
      do_run(1, 1'b1, 1'b0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prga_decrypt.md
Name: prga_decrypt

Overview:
- Second half of the RC4 datapath, run after the key-schedule block has initialised and shuffled the 256-byte S RAM.
- Reads S, continues the swaps, and generates the keystream. XORs the keystream with an encrypted-message ROM and writes the plaintext to a decrypted-message RAM.
- Optionally aborts on the first non-printable byte, so a key-search controller can reject a wrong key early.

Parameters:
- MSG_LEN, 32: number of message bytes to decrypt (1..2**MSG_AW).
- MSG_AW, 5: address width of the message ROM and the decrypted RAM.
- CHECK_ASCII, 1: 1 enables the plaintext check (byte must be 8'h20 or 8'h61..8'h7A); 0 disables it.

Ports:
- clk  in  1  system clock. This block has one clock.
- reset  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle request; sampled only while not busy.
- busy  out  1  high from the cycle after start is accepted until DONE/FAIL.
- done  out  1  all MSG_LEN bytes written; held until next accepted start or reset.
- fail  out  1  check failed; held until next accepted start or reset.
- s_addr  out  8  S RAM address.
- s_data  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- s_q  in  8  S RAM read data, valid the cycle after the address is presented.
- e_addr  out  MSG_AW  encrypted ROM address.
- e_q  in  8  ROM data, 1-cycle latency.
- d_addr  out  MSG_AW  decrypted RAM address.
- d_data  out  8  decrypted RAM write data.
- d_wren  out  1  decrypted RAM write enable.

Behaviour:
- Registers: i, j, si, sj (8 bit); k (MSG_AW bit); state.
- All arithmetic on i, j, si, sj is mod 256 (8-bit wrap).
- Memory outputs are combinational decodes of the registered state.
- When the state does not drive a memory output, address and data are 0 and wren is 0.

- Reset state: state=IDLE; i=j=k=0; busy=done=fail=0; s_wren=d_wren=0.
- Reset mid-operation wins over everything: return to IDLE within one cycle, and issue no further writes.

- IDLE/DONE/FAIL:
  - start=1 → clear i, j, k, done, fail; go to INC.
  - start is ignored in every other state.

- Per byte, 9 cycles:
  - INC: i<=i+1.
  - RD_SI: s_addr=i.
  - LT_SI: si<=s_q; j<=j+s_q.
  - RD_SJ: s_addr=j.
  - LT_SJ: sj<=s_q.
  - WR_I: s_addr=i, s_data=sj, s_wren=1.
  - WR_J: s_addr=j, s_data=si, s_wren=1.
  - RD_F: s_addr=si+sj; e_addr=k.
  - WR_OUT: d_addr=k, d_data=s_q^e_q, d_wren=1.

- Leaving WR_OUT:
  - If CHECK_ASCII and d_data is invalid → FAIL. The byte is still written.
  - Else if k==MSG_LEN-1 → DONE.
  - Else k<=k+1, go to INC.

- i==j: the two writes store the same value. This is a correct self-swap and needs no special case.
- No read shares a cycle with a write to the same RAM, so RAM read-during-write mode is irrelevant.
- Timing, with start accepted in cycle 0:
  - Byte k is written in cycle 9k+9.
  - done (or fail) first goes high in the cycle after the last WR_OUT, e.g. cycle 9*MSG_LEN+1.
- busy=1 in every state except IDLE/DONE/FAIL.
- done and fail are never high together.

Test Plan:
- Identity S (S[n]=n), MSG_LEN=3, CHECK_ASCII=0, ROM={00,00,00}.
  - Required: d writes 02,05,07 at addr 0,1,2 in cycles 9,18,27.
  - Required: done rises in cycle 28.
  - Required: final S[2]=3, S[3]=5, S[5]=2.
- Identity S, CHECK_ASCII=1, ROM={63,64,66} → plaintext 61,61,61; done=1, fail=0.
- Identity S, CHECK_ASCII=1, ROM={63,05,66}:
  - Required: byte1=00 is written, then fail=1.
  - Required: exactly 2 d_wren pulses, done=0.
- start re-pulsed while busy → ignored; timing and outputs identical to the first scenario.
- reset asserted at cycle 14 (mid-swap) → next cycle IDLE, all outputs 0, no further writes. A following start replays the first scenario exactly.
- After done, a new start → done and fail cleared the next cycle, busy=1, i/j/k restart from 0.
